// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path. This file holds the state codes,
// the opcode/funct values, the ALU/PC/RegDst select codes and the strobe bundle type.
package multi_cycle_control_pkg;

  localparam logic [3:0] ST_IF     = 4'd0;
  localparam logic [3:0] ST_ID     = 4'd1;
  localparam logic [3:0] ST_EXE_AL = 4'd2;
  localparam logic [3:0] ST_WB_AL  = 4'd3;
  localparam logic [3:0] ST_EXE_BR = 4'd4;
  localparam logic [3:0] ST_EXE_LS = 4'd5;
  localparam logic [3:0] ST_MEM    = 4'd6;
  localparam logic [3:0] ST_WB_LD  = 4'd7;
  localparam logic [3:0] ST_HALT   = 4'd8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;

  localparam logic [1:0] PC_PC4    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  typedef struct packed {
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic       InsMemRW;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       ExtSel;
    logic       mRD;
    logic       mWR;
  } ctrlT;

  // R-type functs that go through EXE_AL/WB_AL (jr is handled in ID)
  function automatic logic isRAlu(input logic [5:0] funct);
    case (funct)
      FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] aluOpFor(input logic [5:0] opcode, input logic [5:0] funct);
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  return ALU_SUB;
        FN_AND:  return ALU_AND;
        FN_OR:   return ALU_OR;
        FN_SLT:  return ALU_SLT;
        FN_SLL:  return ALU_SLL;
        default: return ALU_ADD;
      endcase
    end
    case (opcode)
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_decode.sv
// Combinational strobe decode from (state, opcode, funct, zero).
// enable low forces every strobe and select to 0.
module multi_cycle_control_decode
  import multi_cycle_control_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic       enable,
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output ctrlT       ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.PCSrc  = PC_PC4;
    ctrl.RegDst = RD_RT;
    ctrl.ALUOp  = ALU_ADD;
    if (enable) begin
      case (state)
        ST_IF: begin
          ctrl.InsMemRW = 1'b1;
          ctrl.IRWre    = 1'b1;
        end
        ST_ID: begin
          if (opcode != HALT_OP) begin
            case (opcode)
              OP_J: begin
                ctrl.PCSrc = PC_JUMP;
                ctrl.PCWre = 1'b1;
              end
              OP_JAL: begin
                ctrl.RegWre    = 1'b1;
                ctrl.RegDst    = RD_R31;
                ctrl.WrRegDSrc = 1'b1;
                ctrl.PCSrc     = PC_JUMP;
                ctrl.PCWre     = 1'b1;
              end
              OP_RTYPE: begin
                if (funct == FN_JR) begin
                  ctrl.PCSrc = PC_RS;
                  ctrl.PCWre = 1'b1;
                end else if (!isRAlu(funct)) begin
                  ctrl.PCWre = 1'b1;
                end
              end
              OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_SLTI: begin
              end
              // Unknown opcodes retire as a nop
              default: ctrl.PCWre = 1'b1;
            endcase
          end
        end
        ST_EXE_AL: begin
          ctrl.ALUOp   = aluOpFor(opcode, funct);
          ctrl.ALUSrcA = (opcode == OP_RTYPE) && (funct == FN_SLL);
          ctrl.ALUSrcB = (opcode != OP_RTYPE);
          ctrl.ExtSel  = (opcode != OP_ORI);
        end
        ST_WB_AL: begin
          ctrl.RegWre = 1'b1;
          ctrl.RegDst = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
          ctrl.PCWre  = 1'b1;
        end
        ST_EXE_BR: begin
          ctrl.ALUOp = ALU_SUB;
          ctrl.PCWre = 1'b1;
          if ((opcode == OP_BEQ) ? zero : !zero) ctrl.PCSrc = PC_BRANCH;
        end
        ST_EXE_LS: begin
          ctrl.ALUOp   = ALU_ADD;
          ctrl.ALUSrcB = 1'b1;
          ctrl.ExtSel  = 1'b1;
        end
        ST_MEM: begin
          if (opcode == OP_LW) begin
            ctrl.mRD = 1'b1;
          end else begin
            ctrl.mWR   = 1'b1;
            ctrl.PCWre = 1'b1;
          end
        end
        ST_WB_LD: begin
          ctrl.RegWre    = 1'b1;
          ctrl.RegDst    = RD_RT;
          ctrl.DBDataSrc = 1'b1;
          ctrl.PCWre     = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: state register plus next-state logic.
// All strobes come from the decode sub-module.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter logic [5:0]  HALT_OP = 6'h3F,
  parameter int unsigned STATE_W = 4
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [STATE_W-1:0] state,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               DBDataSrc,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic               ExtSel,
  output logic               mRD,
  output logic               mWR
);

  logic [3:0] stReg;
  logic [3:0] nextSt;
  ctrlT       ctrl;

  always_comb begin
    nextSt = stReg;
    case (stReg)
      ST_IF: nextSt = ST_ID;
      ST_ID: begin
        if (opcode == HALT_OP) begin
          nextSt = ST_HALT;
        end else begin
          case (opcode)
            OP_RTYPE:                  nextSt = isRAlu(funct) ? ST_EXE_AL : ST_IF;
            OP_BEQ, OP_BNE:            nextSt = ST_EXE_BR;
            OP_LW, OP_SW:              nextSt = ST_EXE_LS;
            OP_ADDI, OP_ORI, OP_SLTI:  nextSt = ST_EXE_AL;
            default:                   nextSt = ST_IF;
          endcase
        end
      end
      ST_EXE_AL: nextSt = ST_WB_AL;
      ST_EXE_LS: nextSt = ST_MEM;
      ST_MEM:    nextSt = (opcode == OP_LW) ? ST_WB_LD : ST_IF;
      ST_HALT:   nextSt = ST_HALT;
      default:   nextSt = ST_IF;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) stReg <= ST_IF;
    else      stReg <= nextSt;
  end

  // Gating with CLR keeps IF's strobes low while reset is held
  multi_cycle_control_decode #(
    .HALT_OP(HALT_OP)
  ) uDecode (
    .enable(CLR),
    .state (stReg),
    .opcode(opcode),
    .funct (funct),
    .zero  (zero),
    .ctrl  (ctrl)
  );

  assign state     = STATE_W'(stReg);
  assign PCWre     = ctrl.PCWre;
  assign PCSrc     = ctrl.PCSrc;
  assign IRWre     = ctrl.IRWre;
  assign InsMemRW  = ctrl.InsMemRW;
  assign RegWre    = ctrl.RegWre;
  assign RegDst    = ctrl.RegDst;
  assign WrRegDSrc = ctrl.WrRegDSrc;
  assign DBDataSrc = ctrl.DBDataSrc;
  assign ALUSrcA   = ctrl.ALUSrcA;
  assign ALUSrcB   = ctrl.ALUSrcB;
  assign ALUOp     = ctrl.ALUOp;
  assign ExtSel    = ctrl.ExtSel;
  assign mRD       = ctrl.mRD;
  assign mWR       = ctrl.mWR;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: per-instruction expected strobe sequences built from an
// instruction table, compared cycle by cycle against the DUT under random instruction streams.
module tb_multi_cycle_control;
  import multi_cycle_control_pkg::ST_IF;
  import multi_cycle_control_pkg::ST_ID;
  import multi_cycle_control_pkg::ST_EXE_AL;
  import multi_cycle_control_pkg::ST_WB_AL;
  import multi_cycle_control_pkg::ST_EXE_BR;
  import multi_cycle_control_pkg::ST_EXE_LS;
  import multi_cycle_control_pkg::ST_MEM;
  import multi_cycle_control_pkg::ST_WB_LD;
  import multi_cycle_control_pkg::ST_HALT;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic [3:0] state;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, DBDataSrc;
  logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;

  multi_cycle_control dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .state    (state),
    .PCWre    (PCWre),
    .PCSrc    (PCSrc),
    .IRWre    (IRWre),
    .InsMemRW (InsMemRW),
    .RegWre   (RegWre),
    .RegDst   (RegDst),
    .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ExtSel   (ExtSel),
    .mRD      (mRD),
    .mWR      (mWR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic       InsMemRW;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       ExtSel;
    logic       mRD;
    logic       mWR;
  } outV;

  localparam logic [3:0] C_ALU = 4'd0, C_BR = 4'd1, C_LW = 4'd2, C_SW = 4'd3;
  localparam logic [3:0] C_J = 4'd4, C_JAL = 4'd5, C_JR = 4'd6, C_NOP = 4'd7, C_HALT = 4'd8;
  localparam int NUM_RAND_KINDS = 18;
  localparam int K_ADD = 0, K_BEQ = 9, K_BNE = 10, K_LW = 11, K_JAL = 14, K_HALT = 18;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] cls;
    logic [2:0] alu;
    logic       srcA;
    logic       srcB;
    logic       ext;
  } instrT;

  int  nCmp = 0;
  int  nBad = 0;
  outV expQ[$];

  task automatic checkVal(input string tag, input logic [21:0] got, input logic [21:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic instrT mkI(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] cls,
                                input logic [2:0] alu, input logic a, input logic b,
                                input logic e);
    instrT i;
    i.op = op; i.fn = fn; i.cls = cls; i.alu = alu; i.srcA = a; i.srcB = b; i.ext = e;
    return i;
  endfunction

  // Instruction table: ALU op codes 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll
  function automatic instrT entry(input int k);
    case (k)
      0:       return mkI(6'h00, 6'h20, C_ALU, 3'd0, 1'b0, 1'b0, 1'b1);
      1:       return mkI(6'h00, 6'h22, C_ALU, 3'd1, 1'b0, 1'b0, 1'b1);
      2:       return mkI(6'h00, 6'h24, C_ALU, 3'd2, 1'b0, 1'b0, 1'b1);
      3:       return mkI(6'h00, 6'h25, C_ALU, 3'd3, 1'b0, 1'b0, 1'b1);
      4:       return mkI(6'h00, 6'h2A, C_ALU, 3'd4, 1'b0, 1'b0, 1'b1);
      5:       return mkI(6'h00, 6'h00, C_ALU, 3'd5, 1'b1, 1'b0, 1'b1);
      6:       return mkI(6'h08, 6'h15, C_ALU, 3'd0, 1'b0, 1'b1, 1'b1);
      7:       return mkI(6'h0D, 6'h2C, C_ALU, 3'd3, 1'b0, 1'b1, 1'b0);
      8:       return mkI(6'h0A, 6'h07, C_ALU, 3'd4, 1'b0, 1'b1, 1'b1);
      9:       return mkI(6'h04, 6'h11, C_BR, 3'd0, 1'b0, 1'b0, 1'b0);
      10:      return mkI(6'h05, 6'h32, C_BR, 3'd0, 1'b0, 1'b0, 1'b0);
      11:      return mkI(6'h23, 6'h04, C_LW, 3'd0, 1'b0, 1'b0, 1'b0);
      12:      return mkI(6'h2B, 6'h3F, C_SW, 3'd0, 1'b0, 1'b0, 1'b0);
      13:      return mkI(6'h02, 6'h20, C_J, 3'd0, 1'b0, 1'b0, 1'b0);
      14:      return mkI(6'h03, 6'h08, C_JAL, 3'd0, 1'b0, 1'b0, 1'b0);
      15:      return mkI(6'h00, 6'h08, C_JR, 3'd0, 1'b0, 1'b0, 1'b0);
      16:      return mkI(6'h10, 6'h20, C_NOP, 3'd0, 1'b0, 1'b0, 1'b0);
      17:      return mkI(6'h3E, 6'h00, C_NOP, 3'd0, 1'b0, 1'b0, 1'b0);
      default: return mkI(6'h3F, 6'h00, C_HALT, 3'd0, 1'b0, 1'b0, 1'b0);
    endcase
  endfunction

  function automatic outV blank(input logic [3:0] s);
    outV v;
    v = '0;
    v.st = s;
    return v;
  endfunction

  function automatic outV sample();
    outV v;
    v.st = state; v.PCWre = PCWre; v.PCSrc = PCSrc; v.IRWre = IRWre; v.InsMemRW = InsMemRW;
    v.RegWre = RegWre; v.RegDst = RegDst; v.WrRegDSrc = WrRegDSrc; v.DBDataSrc = DBDataSrc;
    v.ALUSrcA = ALUSrcA; v.ALUSrcB = ALUSrcB; v.ALUOp = ALUOp; v.ExtSel = ExtSel;
    v.mRD = mRD; v.mWR = mWR;
    return v;
  endfunction

  // Expected per-cycle outputs of one instruction, from its class
  task automatic buildExp(input instrT ins, input logic z);
    outV v;
    v = blank(ST_IF); v.InsMemRW = 1'b1; v.IRWre = 1'b1; expQ.push_back(v);
    v = blank(ST_ID);
    case (ins.cls)
      C_J:    begin v.PCSrc = 2'd2; v.PCWre = 1'b1; expQ.push_back(v); end
      C_JAL:  begin
        v.RegWre = 1'b1; v.RegDst = 2'd2; v.WrRegDSrc = 1'b1; v.PCSrc = 2'd2; v.PCWre = 1'b1;
        expQ.push_back(v);
      end
      C_JR:   begin v.PCSrc = 2'd3; v.PCWre = 1'b1; expQ.push_back(v); end
      C_NOP:  begin v.PCWre = 1'b1; expQ.push_back(v); end
      C_HALT: expQ.push_back(v);
      C_BR: begin
        expQ.push_back(v);
        v = blank(ST_EXE_BR); v.ALUOp = 3'd1; v.PCWre = 1'b1;
        v.PCSrc = (((ins.op == 6'h04) && z) || ((ins.op == 6'h05) && !z)) ? 2'd1 : 2'd0;
        expQ.push_back(v);
      end
      C_LW, C_SW: begin
        expQ.push_back(v);
        v = blank(ST_EXE_LS); v.ALUSrcB = 1'b1; v.ExtSel = 1'b1; expQ.push_back(v);
        v = blank(ST_MEM);
        if (ins.cls == C_LW) begin
          v.mRD = 1'b1; expQ.push_back(v);
          v = blank(ST_WB_LD); v.RegWre = 1'b1; v.DBDataSrc = 1'b1; v.PCWre = 1'b1;
          expQ.push_back(v);
        end else begin
          v.mWR = 1'b1; v.PCWre = 1'b1; expQ.push_back(v);
        end
      end
      default: begin
        expQ.push_back(v);
        v = blank(ST_EXE_AL); v.ALUOp = ins.alu; v.ALUSrcA = ins.srcA; v.ALUSrcB = ins.srcB;
        v.ExtSel = ins.ext; expQ.push_back(v);
        v = blank(ST_WB_AL); v.RegWre = 1'b1; v.RegDst = (ins.op == 6'h00) ? 2'd1 : 2'd0;
        v.PCWre = 1'b1; expQ.push_back(v);
      end
    endcase
  endtask

  // Entered in the first half of an IF cycle; returns just after the final posedge
  task automatic runInstr(input int k, input logic z);
    instrT ins;
    outV   obs;
    outV   exp;
    int    n;
    int    pcw;
    ins = entry(k);
    expQ.delete();
    buildExp(ins, z);
    n = expQ.size();
    pcw = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        opcode = ins.op; funct = ins.fn; zero = z;
      end
      #1;
      obs = sample();
      exp = expQ.pop_front();
      checkVal($sformatf("op%02h/fn%02h z%0d cycle%0d", ins.op, ins.fn, z, c + 1), obs, exp);
      pcw += int'(obs.PCWre);
      @(posedge CLK);
    end
    if (ins.cls != C_HALT)
      checkVal($sformatf("pcwre_once op%02h/fn%02h", ins.op, ins.fn), 22'(pcw), 22'd1);
  endtask

  initial begin
    // Reset held from time 0
    #2;
    checkVal("reset_state", sample(), blank(ST_IF));
    @(posedge CLK);
    #1 CLR = 1'b1;

    runInstr(K_ADD, 1'b0);
    runInstr(K_LW, 1'b1);
    runInstr(K_BEQ, 1'b1);
    runInstr(K_BEQ, 1'b0);
    runInstr(K_BNE, 1'b0);
    runInstr(K_BNE, 1'b1);
    runInstr(K_JAL, 1'b0);

    for (int i = 0; i < 80; i++)
      runInstr(int'($urandom_range(0, NUM_RAND_KINDS - 1)), 1'($urandom_range(0, 1)));

    // Abort an lw in EXE_LS with an asynchronous reset
    @(negedge CLK);
    opcode = 6'h23; funct = 6'h00;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    #1 CLR = 1'b0;
    #1 checkVal("midreset_async", sample(), blank(ST_IF));
    @(posedge CLK);
    #1 checkVal("midreset_hold", sample(), blank(ST_IF));
    #1 CLR = 1'b1;
    runInstr(K_ADD, 1'b1);

    runInstr(K_HALT, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      zero   = 1'($urandom_range(0, 1));
      #1 checkVal($sformatf("halt_hold%0d", i), sample(), blank(ST_HALT));
      @(posedge CLK);
    end
    @(negedge CLK);
    CLR = 1'b0;
    #1 checkVal("halt_clr", sample(), blank(ST_IF));
    @(posedge CLK);
    #1 CLR = 1'b1;
    runInstr(K_LW, 1'b0);
    runInstr(K_ADD, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
